// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared N:1 mux. It picks one requester fairly,
// captures that requester's word into an output register and hands it downstream with valid/ready.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [IW-1:0]   out_src_q, out_src_d;

  logic [N-1:0]    ereq_s;
  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic [IW:0]     scan_s;
  logic            capture_s;
  logic [W-1:0]    din_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign din_arr[k] = din[k*W +: W];
  end

  // The requester granted on the previous edge is masked so a held request cannot win twice in a row.
  assign ereq_s = req & ~gnt_q;

  // Rotating priority scan starting at ptr; the index wraps modulo N so non-power-of-2 N stays in range.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    scan_s       = '0;
    for (int i = 0; i < N; i++) begin
      scan_s = {1'b0, ptr_q} + (IW+1)'(i);
      if (scan_s >= N_EXT) begin
        scan_s = scan_s - N_EXT;
      end else begin
        scan_s = scan_s;
      end
      if (!pick_found_s && ereq_s[scan_s[IW-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = scan_s[IW-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state and capture decision; gnt is a single-cycle pulse that defaults low.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    capture_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          capture_s = 1'b1;
          state_d   = BUSY;
        end else begin
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (!out_ready) begin
          state_d = BUSY;
        end else if (pick_found_s) begin
          capture_s = 1'b1;
          state_d   = BUSY;
        end else begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (capture_s) begin
      out_data_d         = din_arr[pick_idx_s];
      out_src_d          = pick_idx_s;
      out_valid_d        = 1'b1;
      gnt_d[pick_idx_s]  = 1'b1;
      ptr_d              = (pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + IW'(1);
    end else begin
      gnt_d = '0;
    end
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: an N=4/W=8 instance and an N=3/W=4 instance,
// expected values worked out by hand from the arbitration rules.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req4;
  logic [31:0] din4;
  logic [3:0]  gnt4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_src4;
  logic        out_ready4;

  logic [2:0]  req3;
  logic [11:0] din3;
  logic [2:0]  gnt3;
  logic        out_valid3;
  logic [3:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_ready3;

  int n_checks;
  int n_pass;

  rr_mux_arbiter #(.N(4), .W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req4),
    .din       (din4),
    .gnt       (gnt4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_src   (out_src4),
    .out_ready (out_ready4)
  );

  rr_mux_arbiter #(.N(3), .W(4)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .req       (req3),
    .din       (din3),
    .gnt       (gnt3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_src3 [6];
  logic [2:0] exp_gnt3 [6];

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    req4       = 4'b1111;
    din4       = 32'h13121110;
    out_ready4 = 1'b1;
    req3       = 3'b000;
    din3       = 12'h000;
    out_ready3 = 1'b1;

    // 1: reset held two cycles with all requesting
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("rst_gnt",   32'(gnt4),       32'h0);
      check_eq("rst_valid", 32'(out_valid4), 32'h0);
      check_eq("rst_data",  32'(out_data4),  32'h0);
      check_eq("rst_src",   32'(out_src4),   32'h0);
    end

    // 2: single request from idle, one-cycle latency
    rst  = 1'b0;
    req4 = 4'b0100;
    din4 = 32'h00A50000;
    tick();
    check_eq("t2_gnt",   32'(gnt4),       32'h4);
    check_eq("t2_valid", 32'(out_valid4), 32'h1);
    check_eq("t2_data",  32'(out_data4),  32'hA5);
    check_eq("t2_src",   32'(out_src4),   32'h2);
    req4 = 4'b0000;
    tick();
    check_eq("t2_drain_valid", 32'(out_valid4), 32'h0);
    check_eq("t2_drain_gnt",   32'(gnt4),       32'h0);
    check_eq("t2_drain_data",  32'(out_data4),  32'hA5);
    check_eq("t2_drain_src",   32'(out_src4),   32'h2);

    // ptr is 3 now, so requester 3 beats requester 0
    req4 = 4'b1001;
    din4 = 32'h13121110;
    tick();
    check_eq("ptr3_src", 32'(out_src4), 32'h3);
    check_eq("ptr3_gnt", 32'(gnt4),     32'h8);

    // 3: reset, then all four requesting continuously
    rst  = 1'b1;
    req4 = 4'b1111;
    tick();
    check_eq("t3_rst_valid", 32'(out_valid4), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("t3_src",   32'(out_src4),   32'(c % 4));
      check_eq("t3_gnt",   32'(gnt4),       32'(1 << (c % 4)));
      check_eq("t3_valid", 32'(out_valid4), 32'h1);
      check_eq("t3_data",  32'(out_data4),  32'(8'h10 + 8'(c % 4)));
    end

    // 4: backpressure holds out_src=1 for five cycles
    out_ready4 = 1'b0;
    req4       = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("t4_hold_src",   32'(out_src4),   32'h1);
      check_eq("t4_hold_data",  32'(out_data4),  32'h11);
      check_eq("t4_hold_gnt",   32'(gnt4),       32'h0);
      check_eq("t4_hold_valid", 32'(out_valid4), 32'h1);
    end
    out_ready4 = 1'b1;
    tick();
    check_eq("t4_src",  32'(out_src4),  32'h3);
    check_eq("t4_data", 32'(out_data4), 32'h13);
    check_eq("t4_gnt",  32'(gnt4),      32'h8);

    // 5: reset while stalled, then a lone request from requester 3
    out_ready4 = 1'b0;
    req4       = 4'b1000;
    rst        = 1'b1;
    tick();
    check_eq("t5_valid", 32'(out_valid4), 32'h0);
    check_eq("t5_gnt",   32'(gnt4),       32'h0);
    check_eq("t5_src",   32'(out_src4),   32'h0);
    check_eq("t5_data",  32'(out_data4),  32'h0);
    rst = 1'b0;
    tick();
    check_eq("t5_cap_src",   32'(out_src4),   32'h3);
    check_eq("t5_cap_gnt",   32'(gnt4),       32'h8);
    check_eq("t5_cap_valid", 32'(out_valid4), 32'h1);

    // 6: N=3 with requesters 0 and 2 held, alternation and wrap
    exp_src3 = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
    exp_gnt3 = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
    req3 = 3'b101;
    din3 = 12'h7C9;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("t6_src",   32'(out_src3),   32'(exp_src3[c]));
      check_eq("t6_gnt",   32'(gnt3),       32'(exp_gnt3[c]));
      check_eq("t6_valid", 32'(out_valid3), 32'h1);
      check_eq("t6_data",  32'(out_data3),  (exp_src3[c] == 2'd0) ? 32'h9 : 32'h7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
